// File: rtl/adder_seq_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and slice width.
package adder_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fourbit_adder.sv
// Combinational 4-bit ripple slice: {c_out, s_out} = a_in + b_in + c_in.
module fourbit_adder (
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       c_in,
  output logic [3:0] s_out,
  output logic       c_out
);

  logic [4:0] sum;

  assign sum   = {1'b0, a_in} + {1'b0, b_in} + {4'b0000, c_in};
  assign s_out = sum[3:0];
  assign c_out = sum[4];

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles, LS nibble first,
// with valid/ready handshakes on operand entry and result exit.
module nibble_serial_adder_seq
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_valid_in,
  output logic             start_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             done_valid_out,
  input  logic             done_ready_in,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             busy_out
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIB_W-1:0] a_nib, b_nib, sum_nib;
  logic             nib_co;

  always_comb begin
    a_nib = a_q[NIB_W*int'(idx_q) +: NIB_W];
    b_nib = b_q[NIB_W*int'(idx_q) +: NIB_W];
  end

  fourbit_adder u_slice (
    .a_in  (a_nib),
    .b_in  (b_nib),
    .c_in  (carry_q),
    .s_out (sum_nib),
    .c_out (nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid_in) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[NIB_W*int'(idx_q) +: NIB_W] = sum_nib;
        carry_d = nib_co;
        if (idx_q == IDX_LAST) begin
          c_d     = nib_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (done_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
    end
  end

  // Carry into the MSB is recovered from the sum bit rather than stored.
  assign ovf_out         = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_q[WIDTH-1]) ^ c_q;
  assign s_out           = s_q;
  assign c_out           = c_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign start_ready_out = ~busy_out;
  assign done_valid_out  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Directed self-checking bench for nibble_serial_adder_seq at WIDTH=16.
module tb_nibble_serial_adder_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder_seq #(.WIDTH(16)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .start_valid_in  (start_valid),
    .start_ready_out (start_ready),
    .a_in            (a),
    .b_in            (b),
    .c_in            (cin),
    .done_valid_out  (done_valid),
    .done_ready_in   (done_ready),
    .s_out           (s),
    .c_out           (cout),
    .ovf_out         (ovf),
    .busy_out        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents operands; returns #1 after the accept edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    int n;
    n = 0;
    while (!start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("issue_ready", 32'(start_ready), 32'd1);
    a = av; b = bv; cin = cv; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until done_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("done_seen", 32'(done_valid), 32'd1);
  endtask

  task automatic finish_op;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec,
                        input logic eo);
    int lat;
    issue(av, bv, cv);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_c"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    finish_op();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s"}, 32'(s), 32'd0);
    check({tag, "_c"}, 32'(cout), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_dv"}, 32'(done_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure plus a start pulse during RUN that must be ignored.
    issue(16'h1234, 16'h4321, 1'b0);
    check("run_busy", 32'(busy), 32'd1);
    check("run_not_ready", 32'(start_ready), 32'd0);
    a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_dv", 32'(done_valid), 32'd1);
      check("bp_s", 32'(s), 32'h5555);
      check("bp_rdy", 32'(start_ready), 32'd0);
    end
    check("bp_c", 32'(cout), 32'd0);
    finish_op();
    repeat (2) @(posedge clk);
    #1;
    check("no_ghost_op", 32'(busy), 32'd0);

    // Asynchronous reset two nibbles into an operation.
    issue(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
